// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Controls the reset/lock interface of a PLL. The block runs on the free-running
//   reference clock. After power-up or a button reset, it pulses the PLL reset.
//   It then waits for lock and re-pulses the PLL reset if lock does not arrive in
//   time. Lock must then stay stable for a set number of cycles before the system
//   reset for the PLL-derived clock domains is released. If lock is lost for long
//   enough while running, the block reasserts the system reset and re-initialises
//   the PLL. Two saturating 8-bit counters record lock timeouts and losses of lock.
//
// Handshake/protocol note:
//   pll_locked is a level, not a valid/ready handshake. It is asynchronous to
//   refclk, so it passes through a two-flop synchroniser first. The FSM only ever
//   uses the synchronised copy. Every output is a pure decode of registered state,
//   with no combinational path from any input.
//
// Ports:
//   refclk         in   1  free-running reference clock (the only clock)
//   rst            in   1  asynchronous active-high reset
//   pll_locked     in   1  PLL lock indicator, asynchronous to refclk
//   pll_rst        out  1  reset to the PLL, active high (only in PLL_RESET)
//   sys_rst        out  1  system reset for PLL-clocked logic (low only in RUN)
//   sys_ready      out  1  high only in RUN
//   timeout_cnt    out  8  lock timeouts, saturates at 255
//   lock_loss_cnt  out  8  losses of lock in RUN, saturates at 255
//   fsm_state      out  2  debug: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int CNT_W         = 16,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       sys_ready,
    output logic [7:0] timeout_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Terminal values of the shared cycle counter. Each count runs from 0 up to
    // N-1, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;
    logic             lock_meta_q;
    logic             locked_s_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_PLL_RESET;
            cnt_q           <= '0;
            glitch_q        <= '0;
            timeout_cnt_q   <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            glitch_q        <= glitch_d;
            timeout_cnt_q   <= timeout_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        glitch_d        = glitch_q;
        timeout_cnt_d   = timeout_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        unique case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout, so a lock that arrives on
                // the final wait cycle is taken and is not counted as a timeout.
                if (locked_s_q) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_PLL_RESET;
                    cnt_d         = '0;
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STABILIZE: begin
                if (!locked_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = ST_RUN;
                    glitch_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // Short unlocked runs are tolerated. Only GLITCH_CYCLES consecutive
                // unlocked cycles count as a real loss of lock.
                if (locked_s_q) begin
                    glitch_d = '0;
                end else if (glitch_q == GLITCH_LAST) begin
                    state_d         = ST_PLL_RESET;
                    cnt_d           = '0;
                    glitch_d        = '0;
                    lock_loss_cnt_d = sat_inc(lock_loss_cnt_q);
                end else begin
                    glitch_d = glitch_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        pll_rst   = (state_q == ST_PLL_RESET);
        sys_rst   = (state_q != ST_RUN);
        sys_ready = (state_q == ST_RUN);
    end

    assign timeout_cnt   = timeout_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with short cycle parameters. Inputs
// change on the falling edge of refclk. Outputs are sampled on the falling edge
// as well, so each tick() covers exactly one active rising edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       sys_ready;
    logic [7:0] timeout_cnt;
    logic [7:0] lock_loss_cnt;
    logic [1:0] fsm_state;

    int vectors;
    int miscompares;

    pll_reset_sequencer #(
        .CNT_W        (16),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .GLITCH_CYCLES(3)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .sys_ready    (sys_ready),
        .timeout_cnt  (timeout_cnt),
        .lock_loss_cnt(lock_loss_cnt),
        .fsm_state    (fsm_state)
    );

    // Clock/reset block
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed run still active, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_pll_rst, input logic e_sys_rst,
                              input logic e_ready, input logic [1:0] e_state);
        check({tag, ".pll_rst"},   32'(pll_rst),   32'(e_pll_rst));
        check({tag, ".sys_rst"},   32'(sys_rst),   32'(e_sys_rst));
        check({tag, ".sys_ready"}, 32'(sys_ready), 32'(e_ready));
        check({tag, ".fsm_state"}, 32'(fsm_state), 32'(e_state));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        pll_locked  = 1'b0;

        // Reset state
        ticks(2);
        check_outs("reset", 1'b1, 1'b1, 1'b0, 2'd0);
        check("reset.timeout_cnt",   32'(timeout_cnt),   32'd0);
        check("reset.lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // 1: reset pulse is 4 cycles, then lock is raised 5 cycles later
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t1.pll_rst_%0d", i), 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
        end
        check("t1.wait_state", 32'(fsm_state), 32'd1);
        ticks(5);
        pll_locked = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 2)  check("t1.still_wait", 32'(fsm_state), 32'd1);
            if (i == 3)  check("t1.stabilize",  32'(fsm_state), 32'd2);
            if (i == 10) check_outs("t1.edge10", 1'b0, 1'b1, 1'b0, 2'd2);
            if (i == 11) check_outs("t1.edge11", 1'b0, 1'b0, 1'b1, 2'd3);
        end

        // 3a: two-cycle dropout in RUN is ignored
        pll_locked = 1'b0;
        ticks(2);
        pll_locked = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("t3a.ready_%0d", i), 32'(sys_ready), 32'd1);
        end
        check_outs("t3a.end", 1'b0, 1'b0, 1'b1, 2'd3);
        check("t3a.lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // 3b: three-cycle dropout is a loss of lock (pll_locked kept low afterwards)
        pll_locked = 1'b0;
        ticks(4);
        check_outs("t3b.edge4", 1'b0, 1'b0, 1'b1, 2'd3);
        tick();
        check_outs("t3b.edge5", 1'b1, 1'b1, 1'b0, 2'd0);
        check("t3b.lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        ticks(4);
        check_outs("t3b.wait", 1'b0, 1'b1, 1'b0, 2'd1);

        // 4: drop lock in STABILIZE after 5 locked cycles, then relock
        pll_locked = 1'b1;
        ticks(3);
        check("t4.stabilize", 32'(fsm_state), 32'd2);
        ticks(3);
        pll_locked = 1'b0;
        ticks(2);
        check("t4.cnt5_still_stab", 32'(fsm_state), 32'd2);
        tick();
        check_outs("t4.back_to_wait", 1'b0, 1'b1, 1'b0, 2'd1);
        check("t4.timeout_cnt",   32'(timeout_cnt),   32'd0);
        check("t4.lock_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        pll_locked = 1'b1;
        ticks(3);
        check("t4.restab", 32'(fsm_state), 32'd2);
        ticks(7);
        check_outs("t4.stab7", 1'b0, 1'b1, 1'b0, 2'd2);
        tick();
        check_outs("t4.run", 1'b0, 1'b0, 1'b1, 2'd3);

        // Second loss of lock, leaving pll_locked low
        pll_locked = 1'b0;
        ticks(5);
        check("t6.loss_state", 32'(fsm_state), 32'd0);
        check("t6.lock_loss_cnt", 32'(lock_loss_cnt), 32'd2);
        ticks(4);
        check("t6.wait_cnt0", 32'(fsm_state), 32'd1);

        // 6: locked_s rises on the cycle where the wait count is 19
        ticks(17);
        pll_locked = 1'b1;
        ticks(2);
        check("t6.cnt19_wait", 32'(fsm_state), 32'd1);
        tick();
        check_outs("t6.lock_wins", 1'b0, 1'b1, 1'b0, 2'd2);
        check("t6.timeout_cnt", 32'(timeout_cnt), 32'd0);
        ticks(8);
        check_outs("t6.run", 1'b0, 1'b0, 1'b1, 2'd3);
        check("t6.run_loss", 32'(lock_loss_cnt), 32'd2);

        // 5: asynchronous reset in the middle of the low clock phase
        #2;
        rst = 1'b1;
        #1;
        check_outs("t5.async", 1'b1, 1'b1, 1'b0, 2'd0);
        check("t5.timeout_cnt",   32'(timeout_cnt),   32'd0);
        check("t5.lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        pll_locked = 1'b0;
        ticks(2);
        check_outs("t5.held", 1'b1, 1'b1, 1'b0, 2'd0);

        // 2: no lock ever; 24-cycle retry period, timeout counter saturates
        rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            for (int j = 1; j <= 24; j++) begin
                logic       e_rst;
                logic [7:0] e_to;
                int         n;
                tick();
                e_rst = (j < 4) || (j == 24);
                n     = (j == 24) ? k : k - 1;
                e_to  = (n > 255) ? 8'd255 : 8'(n);
                check($sformatf("t2.pll_rst_p%0d_c%0d", k, j), 32'(pll_rst), 32'(e_rst));
                check($sformatf("t2.timeout_p%0d_c%0d", k, j), 32'(timeout_cnt), 32'(e_to));
                if (j == 24) check($sformatf("t2.sys_rst_p%0d", k), 32'(sys_rst), 32'd1);
            end
        end
        check("t2.saturated", 32'(timeout_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
